cnn_kernel_scheduler: RTL

Sequences the single-kernel 3x3 convolution engine over a layer of several kernels. For each kernel it performs three steps in order:
- fetches the kernel's weights plus bias from the on-chip weight memory into the engine's kernel bus;
- requests one full image pass from the DMA and forwards those pixels to the engine;
- waits until every convolution result has been produced.

It sits between the DMA, the weight memory and the convolution engine, and is the only block that changes the engine's kernel.

---
 rtl/cnn_kernel_scheduler_if.sv | 29 ++
 rtl/cnn_kernel_scheduler.sv | 99 +++++++++
 2 files changed

// File: rtl/cnn_kernel_scheduler_if.sv
// cnn_kernel_scheduler_if: weight memory, DMA and engine signals around the kernel scheduler
interface cnn_kernel_scheduler_if #(
  parameter int DATA_RES = 8,
  parameter int WEIGHT_RES = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int MAX_DIM = 32,
  parameter int MAX_KERNELS = 8
);
  localparam int AW = $clog2(MAX_KERNELS*(KERNEL_SIZE+1));
  logic w_rd_en;
  logic [AW-1:0] w_addr;
  logic [WEIGHT_RES-1:0] w_data;
  logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0] kernel;
  logic [$clog2(MAX_KERNELS)-1:0] kernel_idx;
  logic dma_req;
  logic dma_valid;
  logic [DATA_RES-1:0] dma_pixel;
  logic eng_valid;
  logic [DATA_RES-1:0] eng_pixel;
  logic eng_out_valid;
  modport master (
    output w_rd_en, w_addr, kernel, kernel_idx, dma_req, eng_valid, eng_pixel,
    input w_data, dma_valid, dma_pixel, eng_out_valid
  );
  modport slave (
    input w_rd_en, w_addr, kernel, kernel_idx, dma_req, eng_valid, eng_pixel,
    output w_data, dma_valid, dma_pixel, eng_out_valid
  );
endinterface

// File: rtl/cnn_kernel_scheduler.sv
// cnn_kernel_scheduler: runs load-weights / stream-image / drain-results per kernel of a layer
module cnn_kernel_scheduler #(
  parameter int DATA_RES = 8,
  parameter int WEIGHT_RES = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int MAX_DIM = 32,
  parameter int MAX_KERNELS = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic [$clog2(MAX_KERNELS+1)-1:0] num_kernels_i,
  input  logic [$clog2(MAX_DIM)-1:0] image_dimension_i,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
  output logic [2:0] state_o,
  cnn_kernel_scheduler_if.master bus
);
  localparam int NW = $clog2(MAX_KERNELS+1);
  localparam int DW = $clog2(MAX_DIM);
  localparam int KW = $clog2(MAX_KERNELS);
  localparam int AW = $clog2(MAX_KERNELS*(KERNEL_SIZE+1));
  localparam int CW = $clog2(MAX_DIM*MAX_DIM)+1;
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int LW = $clog2(KERNEL_SIZE+2);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [NW-1:0] nk;
  logic [DW-1:0] dim;
  logic [KW-1:0] k;
  logic [LW-1:0] lcnt;
  logic [CW-1:0] in_cnt, out_cnt, pix_total, out_total;
  logic [TW-1:0] tmo;
  logic [WEIGHT_RES*(KERNEL_SIZE+1)-1:0] kernel_q;
  logic err;
  logic in_last, out_hit, timed_out, last_kernel, active;
  assign pix_total = CW'(dim) * CW'(dim);
  assign out_total = (CW'(dim) - CW'(2)) * (CW'(dim) - CW'(2));
  assign in_last = bus.dma_valid && (in_cnt + CW'(1) == pix_total);
  assign out_hit = out_cnt == out_total;
  assign timed_out = tmo == TW'(TIMEOUT-1) && !bus.eng_out_valid;
  assign last_kernel = NW'(k) + NW'(1) == nk;
  assign active = state == STREAM || state == DRAIN;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = num_kernels_i == '0 ? DONE : image_dimension_i < DW'(3) ? IDLE : LOAD_W;
      LOAD_W:  if (lcnt == LW'(KERNEL_SIZE+1)) state_n = STREAM;
      STREAM:  if (in_last) state_n = DRAIN;
      DRAIN:   if (out_hit) state_n = last_kernel ? DONE : LOAD_W;
               else if (timed_out) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      nk <= '0;
      dim <= '0;
      k <= '0;
      lcnt <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      tmo <= '0;
      kernel_q <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_i) begin
        nk <= num_kernels_i;
        dim <= image_dimension_i;
        k <= '0;
        err <= num_kernels_i != '0 && image_dimension_i < DW'(3);
      end
      if (state == DRAIN && !out_hit && timed_out) err <= 1'b1;
      if (state == DRAIN && out_hit && !last_kernel) k <= k + KW'(1);
      lcnt <= state == LOAD_W ? lcnt + LW'(1) : '0;
      // read data lags the strobe by one cycle, so slot j lands while lcnt == j+1
      if (state == LOAD_W && lcnt != '0) kernel_q[(int'(lcnt) - 1) * WEIGHT_RES +: WEIGHT_RES] <= bus.w_data;
      in_cnt <= state == STREAM && bus.dma_valid ? in_cnt + CW'(1) : active ? in_cnt : '0;
      out_cnt <= active ? out_cnt + CW'(bus.eng_out_valid) : '0;
      tmo <= state == DRAIN && !bus.eng_out_valid ? tmo + TW'(1) : '0;
    end
  end
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign error_o = err;
  assign state_o = state;
  assign bus.w_rd_en = state == LOAD_W && lcnt < LW'(KERNEL_SIZE+1);
  assign bus.w_addr = bus.w_rd_en ? AW'(int'(k) * (KERNEL_SIZE+1) + int'(lcnt)) : '0;
  assign bus.kernel = kernel_q;
  assign bus.kernel_idx = k;
  assign bus.dma_req = state == STREAM;
  assign bus.eng_valid = state == STREAM && bus.dma_valid;
  assign bus.eng_pixel = state == STREAM ? bus.dma_pixel : '0;
endmodule
